// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg
//   Shared types and constants for the UART transmit scheduler.
//   Revision: 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } sched_state_t;

    localparam int UART_DBIT    = 8;
    localparam int UART_TIMEOUT = 65535;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter
//   Combinational round-robin pick: first asserted request after `last`.
//   Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [N_REQ-1:0] gnt,
    output logic [GW-1:0]    idx,
    output logic             any
);

    int   k;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        // Walk from the slot after the previous owner, wrapping once.
        for (int off = 1; off <= N_REQ; off++) begin
            k = (int'(last) + off) % N_REQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = GW'(k);
            end
        end
    end

    assign any = |req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// uart_tx_sched
//   Round-robin scheduler sharing one UART transmitter between N requesters.
//   Revision: 1.0
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int DBIT    = UART_DBIT,
    parameter int TIMEOUT = UART_TIMEOUT,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DBIT-1:0]     req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_start,
    output logic [DBIT-1:0]           d_tx,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      err_timeout,
    input  logic                      err_clr
);

    localparam int            GW        = $clog2(N_REQ);
    localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GRANT_RST = GW'(N_REQ - 1);

    sched_state_t      state_q, state_d;
    logic [DBIT-1:0]   d_tx_q, d_tx_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [TW-1:0]     wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              tx_done_q;
    logic              err_set;
    logic              tx_rise;

    logic [N_REQ-1:0]  arb_gnt;
    logic [GW-1:0]     arb_idx;
    logic              arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_arb (
        .req  (req_valid),
        .last (grant_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    assign tx_rise = tx_done & ~tx_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            d_tx_q    <= '0;
            grant_q   <= GRANT_RST;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_tx_q    <= d_tx_d;
            grant_q   <= grant_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            tx_done_q <= tx_done;
        end
    end

    always_comb begin
        state_d = state_q;
        d_tx_d  = d_tx_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = SEND;
                    d_tx_d  = req_data[int'(arb_idx)*DBIT +: DBIT];
                    grant_d = arb_idx;
                    wdog_d  = '0;
                end
            end
            SEND: begin
                // A completion edge on the last watchdog cycle still counts.
                if (tx_rise) begin
                    state_d = RELEASE;
                end else if (wdog_q == WD_LAST) begin
                    err_set = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
            RELEASE: begin
                if (!tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set | (err_q & ~err_clr);
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? arb_gnt : '0;
        tx_start  = (state_q == SEND);
        busy      = (state_q != IDLE);
    end

    assign d_tx        = d_tx_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;

endmodule : uart_tx_sched
`default_nettype wire
